// File: rtl/monte_bus_master.sv
// Bus master that loads a 16-cell board and a seed into a responder, idles for
// WAIT_CYCLES, then reads back 40 result bytes from addresses 17..56.
module monte_bus_master #(
    parameter int unsigned WAIT_CYCLES = 1000,
    parameter int unsigned GNT_TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [95:0]  board,
    input  logic [7:0]   seed_in,
    output logic [15:0]  int_address,
    output logic [7:0]   int_wr_data,
    output logic         int_write,
    output logic         int_read,
    output logic         int_req,
    input  logic         int_gnt,
    input  logic [7:0]   int_rd_data,
    output logic [319:0] results,
    output logic         busy,
    output logic         done,
    output logic         err
);

    typedef enum logic [3:0] {
        IDLE, REQ, WR_GRID, WR_SEED, WAIT, RD, RD_CAP, DONE, ERR
    } state_t;

    state_t           state;
    logic [15:0][5:0] board_q;
    logic [7:0]       seed_q;
    logic [5:0]       idx;
    logic [31:0]      wait_cnt;
    logic [15:0]      tmo_cnt;
    logic [39:0][7:0] res_q;
    logic             tmo_hit;

    assign results = res_q;

    // Strobes follow int_gnt combinationally so a strobe only ever lands in a granted cycle.
    always_comb begin
        tmo_hit     = (tmo_cnt + 16'd1) >= 16'(GNT_TIMEOUT);
        int_req     = !abort && (state inside {REQ, WR_GRID, WR_SEED, WAIT, RD, RD_CAP});
        int_write   = !abort && int_gnt && (state inside {WR_GRID, WR_SEED});
        int_read    = !abort && int_gnt && (state == RD);
        int_address = '0;
        int_wr_data = '0;
        if (int_write) begin
            if (state == WR_GRID) begin
                int_address = {10'd0, idx};
                int_wr_data = {2'b00, board_q[idx[3:0]]};
            end else begin
                int_address = 16'd16;
                int_wr_data = (seed_q == 8'd0) ? 8'h01 : seed_q;
            end
        end
        if (int_read) begin
            int_address = 16'd17 + {10'd0, idx};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            board_q  <= '0;
            seed_q   <= '0;
            idx      <= '0;
            wait_cnt <= '0;
            tmo_cnt  <= '0;
            res_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state    <= IDLE;
                busy     <= 1'b0;
                idx      <= '0;
                wait_cnt <= '0;
                tmo_cnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            board_q <= board;
                            seed_q  <= seed_in;
                            err     <= 1'b0;
                            busy    <= 1'b1;
                            idx     <= '0;
                            tmo_cnt <= '0;
                            state   <= REQ;
                        end
                    end
                    REQ, WR_GRID, WR_SEED, RD: begin
                        if (!int_gnt) begin
                            if (tmo_hit) begin
                                state   <= ERR;
                                err     <= 1'b1;
                                tmo_cnt <= '0;
                            end else begin
                                tmo_cnt <= tmo_cnt + 16'd1;
                            end
                        end else begin
                            tmo_cnt <= '0;
                            case (state)
                                REQ: state <= WR_GRID;
                                WR_GRID: begin
                                    if (idx == 6'd15) begin
                                        idx   <= '0;
                                        state <= WR_SEED;
                                    end else begin
                                        idx <= idx + 6'd1;
                                    end
                                end
                                WR_SEED: begin
                                    wait_cnt <= '0;
                                    state    <= (WAIT_CYCLES == 0) ? RD : WAIT;
                                end
                                default: state <= RD_CAP;
                            endcase
                        end
                    end
                    WAIT: begin
                        if (wait_cnt == WAIT_CYCLES - 1) begin
                            wait_cnt <= '0;
                            state    <= RD;
                        end else begin
                            wait_cnt <= wait_cnt + 32'd1;
                        end
                    end
                    RD_CAP: begin
                        res_q[idx] <= int_rd_data;
                        if (idx == 6'd39) begin
                            idx   <= '0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            idx   <= idx + 6'd1;
                            state <= RD;
                        end
                    end
                    DONE, ERR: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
